// File: rtl/cmp_serial_if.sv
// Bundle for the bit-serial comparator: operand bit stream in, verdict and status out.
interface cmp_serial_if #(
  parameter int WIDTH = 8
) ();
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             start;
  logic             in_valid;
  logic             a_bit;
  logic             b_bit;
  logic             busy;
  logic             done;
  logic             gt;
  logic             eq;
  logic             lt;
  logic [CNT_W-1:0] count;

  // Bit pairs carry in_valid only, with no ready: every in_valid cycle in SHIFT is
  // accepted. Outside SHIFT, and in a cycle where start is also high, the pair is dropped.
  modport master (
    output start, in_valid, a_bit, b_bit,
    input  busy, done, gt, eq, lt, count
  );

  modport slave (
    input  start, in_valid, a_bit, b_bit,
    output busy, done, gt, eq, lt, count
  );
endinterface

// File: rtl/cmp_serial.sv
// Bit-serial MSB-first magnitude comparator accumulating a gt/eq/lt verdict per frame.
// Optional macro CMP_SERIAL_SIGNED_EN selects two's-complement operands.
module cmp_serial #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  cmp_serial_if.slave   bus,
  output logic [1:0]    o_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  state_t           r_state;
  logic             r_busy;
  logic             r_done;
  logic             r_gt;
  logic             r_eq;
  logic             r_lt;
  logic [CNT_W-1:0] r_count;

  logic w_first;
  logic w_decided;
  logic w_differ;
  logic w_a_wins;

  assign w_first   = (r_count == '0);
  assign w_decided = r_gt | r_lt;
  assign w_differ  = bus.a_bit ^ bus.b_bit;

`ifdef CMP_SERIAL_SIGNED_EN
  // The sign bit weighs negatively, so a 1 there marks the smaller operand.
  assign w_a_wins = w_first ? bus.b_bit : bus.a_bit;
`else
  assign w_a_wins = bus.a_bit;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_gt    <= 1'b0;
      r_eq    <= 1'b0;
      r_lt    <= 1'b0;
      r_count <= '0;
    end else if (bus.start) begin
      r_state <= S_SHIFT;
      r_busy  <= 1'b1;
      r_done  <= 1'b0;
      r_gt    <= 1'b0;
      r_eq    <= 1'b1;
      r_lt    <= 1'b0;
      r_count <= '0;
    end else begin
      case (r_state)
        S_SHIFT: begin
          if (bus.in_valid) begin
            r_count <= r_count + CNT_W'(1);
            if (!w_decided && w_differ) begin
              r_gt <= w_a_wins;
              r_lt <= ~w_a_wins;
              r_eq <= 1'b0;
            end
            if (r_count == LAST_IDX) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= r_state;
        end
      endcase
    end
  end

  assign bus.busy  = r_busy;
  assign bus.done  = r_done;
  assign bus.gt    = r_gt;
  assign bus.eq    = r_eq;
  assign bus.lt    = r_lt;
  assign bus.count = r_count;
  assign o_state   = r_state;

endmodule

// File: tb/tb_cmp_serial.sv
// Directed self-checking bench for cmp_serial (WIDTH=8), linear stimulus in one initial block.
module tb_cmp_serial;

  localparam int WIDTH = 8;
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;

  int checks   = 0;
  int failures = 0;

  // expected verdict per frame, packed {gt, eq, lt}
  logic [2:0] exp_q[$];

  cmp_serial_if #(.WIDTH(WIDTH)) bus ();

  cmp_serial #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .o_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.a_bit    = 1'b0;
    bus.b_bit    = 1'b0;
  endtask

  task automatic do_start();
    bus.start    = 1'b1;
    bus.in_valid = 1'b0;
    tick();
    bus.start    = 1'b0;
    chk("start_busy", {7'd0, bus.busy}, 8'd1);
    chk("start_verdict", {5'd0, bus.gt, bus.eq, bus.lt}, 8'b010);
    chk("start_count", 8'(bus.count), 8'd0);
  endtask

  task automatic send_bit(input logic a, input logic b);
    bus.in_valid = 1'b1;
    bus.a_bit    = a;
    bus.b_bit    = b;
    tick();
    bus.in_valid = 1'b0;
  endtask

  // Full frame with random gaps, then scoreboard check against the queued verdict.
  task automatic run_frame(input logic [7:0] a, input logic [7:0] b, input int max_gap,
                           input string tag);
    logic [2:0] exp_v;
    do_start();
    for (int i = WIDTH - 1; i >= 0; i--) begin
      int gap;
      gap = $urandom_range(max_gap, 0);
      for (int g = 0; g < gap; g++) begin
        bus.a_bit = 1'($urandom_range(1, 0));
        bus.b_bit = 1'($urandom_range(1, 0));
        tick();
      end
      send_bit(a[i], b[i]);
      if (i > 0) chk({tag, "_not_done"}, {7'd0, bus.done}, 8'd0);
    end
    exp_v = exp_q.pop_front();
    chk({tag, "_done"}, {7'd0, bus.done}, 8'd1);
    chk({tag, "_busy"}, {7'd0, bus.busy}, 8'd0);
    chk({tag, "_verdict"}, {5'd0, bus.gt, bus.eq, bus.lt}, {5'd0, exp_v});
    chk({tag, "_count"}, 8'(bus.count), 8'd8);
  endtask

  logic [7:0] a_v;
  logic [7:0] b_v;
  logic [2:0] held_v;

  initial begin
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    chk("rst_busy", {7'd0, bus.busy}, 8'd0);
    chk("rst_done", {7'd0, bus.done}, 8'd0);
    chk("rst_verdict", {5'd0, bus.gt, bus.eq, bus.lt}, 8'b000);
    chk("rst_count", 8'(bus.count), 8'd0);
    rst = 1'b0;
    tick();
    chk("idle_ignores_valid", 8'(bus.count), 8'd0);

    // 1: reset mid-frame after 3 bits
    do_start();
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b1);
    chk("mid_count3", 8'(bus.count), 8'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_busy", {7'd0, bus.busy}, 8'd0);
    chk("midrst_done", {7'd0, bus.done}, 8'd0);
    chk("midrst_verdict", {5'd0, bus.gt, bus.eq, bus.lt}, 8'b000);
    chk("midrst_count", 8'(bus.count), 8'd0);

    // 2: A5 vs 5A, back to back
`ifdef CMP_SERIAL_SIGNED_EN
    exp_q.push_back(3'b001);
`else
    exp_q.push_back(3'b100);
`endif
    run_frame(8'hA5, 8'h5A, 0, "a5_5a");

    // 3: equal operands with gaps
    exp_q.push_back(3'b010);
    run_frame(8'h3C, 8'h3C, 3, "eq_3c");

    // 4: difference only in the LSB
    a_v = 8'h01;
    b_v = 8'h00;
    do_start();
    for (int i = WIDTH - 1; i >= 1; i--) begin
      send_bit(a_v[i], b_v[i]);
      chk("lsb_eq_hold", {5'd0, bus.gt, bus.eq, bus.lt}, 8'b010);
    end
    send_bit(a_v[0], b_v[0]);
    chk("lsb_gt", {5'd0, bus.gt, bus.eq, bus.lt}, 8'b100);
    chk("lsb_done", {7'd0, bus.done}, 8'd1);

    // 5: abort after 4 bits, then 10 vs 20
    do_start();
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
    chk("abort_pre_gt", {7'd0, bus.gt}, 8'd1);
    do_start();
    exp_q.push_back(3'b001);
    run_frame(8'h10, 8'h20, 1, "lt_10_20");

    // 6: DONE holds against input activity
    held_v = {bus.gt, bus.eq, bus.lt};
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'(i % 2);
      bus.a_bit    = 1'((i + 1) % 2);
      bus.b_bit    = 1'(i % 2);
      tick();
    end
    idle_inputs();
    chk("done_hold_verdict", {5'd0, bus.gt, bus.eq, bus.lt}, 8'b001);
    chk("done_hold_count", 8'(bus.count), 8'd8);
    chk("done_hold_done", {7'd0, bus.done}, 8'd1);
    chk("done_hold_state", {6'd0, dbg_state}, 8'd2);
    chk("done_hold_vs_before", {5'd0, bus.gt, bus.eq, bus.lt}, {5'd0, held_v});

    // start and in_valid together: the bit is dropped
    bus.start    = 1'b1;
    bus.in_valid = 1'b1;
    bus.a_bit    = 1'b1;
    bus.b_bit    = 1'b0;
    tick();
    idle_inputs();
    chk("start_drop_count", 8'(bus.count), 8'd0);
    chk("start_drop_verdict", {5'd0, bus.gt, bus.eq, bus.lt}, 8'b010);
    chk("start_drop_busy", {7'd0, bus.busy}, 8'd1);
    tick();
    chk("shift_gap_hold", 8'(bus.count), 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
